// File: rtl/readout_scheduler.sv
// Frame readout controller: header, RTC slot and enabled channel slots shifted out MSB-first.
// Define READOUT_PARITY_EN to append an even-parity bit to every word.
module readout_scheduler #(
  parameter int          N_SLOT  = 16,
  parameter int          WIDTH   = 12,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trigger,
  input  logic [N_SLOT-2:0]          ch_mask,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       sout_ready,
  output logic [$clog2(N_SLOT)-1:0]  sel,
  output logic                       sout,
  output logic                       sout_valid,
  output logic                       busy,
  output logic                       counter_rst,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [7:0]                 frame_seq
);

  localparam int SW = $clog2(N_SLOT);
`ifdef READOUT_PARITY_EN
  localparam int WLEN = WIDTH + 1;
`else
  localparam int WLEN = WIDTH;
`endif
  localparam int CW = $clog2(WLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SHIFT, S_SEL, S_LOAD, S_CLEAR
  } state_t;

  state_t              state;
  logic [WLEN-1:0]     sreg;
  logic [CW-1:0]       bit_cnt;
  logic [SW-1:0]       slot;
  logic                hdr_word;
  logic [N_SLOT-2:0]   mask_q;
  logic                trig_q;
  logic                next_found;
  logic [SW-1:0]       next_slot;

  function automatic logic [WLEN-1:0] frame_word(input logic [WIDTH-1:0] w);
`ifdef READOUT_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Lowest enabled slot above the current one; the header is always followed by slot 0.
  always_comb begin
    next_found = 1'b0;
    next_slot  = '0;
    if (hdr_word) begin
      next_found = 1'b1;
    end else begin
      for (int j = N_SLOT - 1; j >= 1; j--) begin
        if (j > int'(slot) && mask_q[j-1]) begin
          next_found = 1'b1;
          next_slot  = SW'(j);
        end
      end
    end
  end

  // Handshake: a bit transfers on any rising edge where sout_valid && sout_ready;
  // while sout_ready is low in SHIFT, sout and all state hold.
  assign busy       = (state != S_IDLE);
  assign sout_valid = (state == S_SHIFT);
  assign sout       = sout_valid & sreg[WLEN-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      slot        <= '0;
      hdr_word    <= 1'b0;
      mask_q      <= '0;
      trig_q      <= 1'b0;
      sel         <= '0;
      counter_rst <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_seq   <= '0;
    end else begin
      trig_q      <= trigger;
      counter_rst <= 1'b0;
      frame_done  <= 1'b0;
      if (trigger && !trig_q && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            mask_q <= ch_mask;
            state  <= S_HDR;
          end
        end
        S_HDR: begin
          sreg     <= frame_word(WIDTH'({HDR_TAG, frame_seq}));
          bit_cnt  <= CW'(WLEN);
          hdr_word <= 1'b1;
          slot     <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (sout_ready) begin
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt - CW'(1);
            if (bit_cnt == CW'(1)) begin
              hdr_word <= 1'b0;
              if (next_found) begin
                slot  <= next_slot;
                sel   <= next_slot;
                state <= S_SEL;
              end else begin
                sel         <= '0;
                counter_rst <= 1'b1;
                frame_done  <= 1'b1;
                state       <= S_CLEAR;
              end
            end
          end
        end
        S_SEL: state <= S_LOAD;
        S_LOAD: begin
          sreg    <= frame_word(data_in);
          bit_cnt <= CW'(WLEN);
          state   <= S_SHIFT;
        end
        S_CLEAR: begin
          frame_seq <= frame_seq + 8'd1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/readout_scheduler.md
# readout_scheduler

Frame-level readout controller for the spectrogram extractor. When the global overflow (`ovf_global`) asserts, it sequences a complete readout frame: a header word, the RTC counter (slot 0), and each enabled channel counter (slots 1–15). For each slot it drives the 16:1 mux select, captures the 12-bit word, and shifts it out MSB-first under a downstream valid/ready handshake. After the last slot it issues a one-cycle counter-clear pulse to the time and channel counters. It replaces free-running shift-out with a flow-controlled, maskable, sequence-numbered frame.

## Interface
- `N_SLOT`, 16: RTC slot plus channel slots; select width is 4.
- `WIDTH`, 12: counter word width and shift length.
- `HDR_TAG`, 4'hA: header nibble.

- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `trigger` input 1: level; connects to `ovf_global`.
- `ch_mask` input 15: bit i-1 = 1 enables channel i; slot 0 (RTC) is always sent.
- `data_in` input WIDTH: mux output for the current `sel`.
- `sout_ready` input 1: downstream accepts the current bit.
- `sel` output 4: mux select.
- `sout` output 1: serial data, MSB first.
- `sout_valid` output 1: `sout` holds a frame bit.
- `busy` output 1: high in every state except IDLE.
- `counter_rst` output 1: one-cycle clear pulse to the counters.
- `frame_done` output 1: one-cycle pulse, coincident with `counter_rst`.
- `overrun` output 1: sticky flag; cleared only by `reset`.
- `frame_seq` output 8: sequence number of the next frame.

## Operation
- States and transitions:
  - IDLE → HDR when `trigger` is high.
  - HDR → SHIFT after one cycle.
  - SHIFT → SEL or CLEAR after the last bit is accepted.
  - SEL → LOAD after one cycle.
  - LOAD → SHIFT after one cycle.
  - CLEAR → IDLE after one cycle.
- IDLE: on `trigger`=1, latch `ch_mask` into `mask_q`. `mask_q` governs the whole frame; later `ch_mask` changes have no effect on it.
- HDR: load the shift register with {HDR_TAG, frame_seq}. The first SHIFT after HDR is the header word.
- SEL: drive `sel` = slot. This cycle is the mux settle time.
- LOAD: hold `sel` and capture `data_in` into the shift register.
- SHIFT:
  - `sout_valid`=1 and `sout` = shift register MSB.
  - When `sout_ready`=1, shift left and decrement the bit counter. When `sout_ready`=0, hold all state (stall).
  - After the WIDTH-th accepted bit:
    - After the header word, go to SEL with slot 0.
    - Otherwise, go to SEL with the next enabled slot greater than the current slot.
    - If no enabled slot remains, go to CLEAR.
    - Slot search is combinational; a masked slot costs zero cycles.
- CLEAR:
  - `counter_rst`=1 and `frame_done`=1 for exactly one cycle.
  - `frame_seq` increments modulo 256 (255 → 0).
  - `sel` returns to 0.
- `overrun`: set when `trigger` has a rising edge (compared against its registered copy) while `busy`=1.
- `trigger` is not re-sampled until IDLE. A level still high in IDLE after CLEAR starts a new frame on the next cycle.
- `sout` is 0 whenever `sout_valid`=0.

## Timing
- Reset values: `sel`=0, `sout`=0, `sout_valid`=0, `busy`=0, `counter_rst`=0, `frame_done`=0, `overrun`=0, `frame_seq`=0, state IDLE.
- Reset mid-frame: return to IDLE on the next edge. No `counter_rst` pulse is issued and `frame_seq` is not incremented.
- Cycle t = IDLE cycle with `trigger`=1 sampled; `sout_ready`=1 throughout:
  - t+1: HDR.
  - t+2 to t+13: header bits.
  - Slot k enabled: SEL at t+14+14k, LOAD at t+15+14k, bits at t+16+14k through t+27+14k.
  - All slots enabled: CLEAR at t+238; `busy` falls at t+239.
- Per word: 2 overhead cycles plus WIDTH shift cycles, plus one cycle per stall.
- Latency from `sout_ready` to the next bit: 0 cycles (`sout` is registered and `sout_valid` is combinational from state).

## Configuration
- `READOUT_PARITY_EN` defined:
  - Each word (header included) is followed by one even-parity bit, computed over the WIDTH data bits at load time.
  - Words are WIDTH+1 bits, and the shift counter counts WIDTH+1.
  - Full frame: CLEAR at t+255.
- Not defined: words are WIDTH bits; no parity logic is synthesized.

## Test plan
- Full frame: `ch_mask`=15'h7FFF, `data_in`=sel×12'h111, `sout_ready`=1, `trigger` pulse → words A00, 000, 111, …, FFF; `counter_rst` single-cycle at t+238; `frame_seq`=1.
- Sparse mask: `ch_mask`=15'h0005 → words A00, slot0, slot1, slot3 only; CLEAR at t+56; `sel` never equals 2 or 4–15.
- Back-pressure: `sout_ready` low for 5 cycles at bit 3 of slot 0 → `sout` held, no bit lost, CLEAR delayed by exactly 5 cycles.
- Sequence wrap: 256 back-to-back frames → 256th header A FF, 257th header A00.
- Reset mid-shift at slot 7 → next cycle IDLE, all outputs at reset values, no `counter_rst`; a new `trigger` produces header A00.
- Overrun: `trigger` drops then re-rises during slot 4 → `overrun`=1 stays set after frame end; cleared only by `reset`. With `READOUT_PARITY_EN`, word 12'h001 is followed by parity bit 1.
